// File: rtl/api_pkg.sv
// Shared constants for the miner-controller Wishbone slave: register addresses,
// magic read words and the STATE register field layout.
package api_pkg;

  localparam logic [5:0] API_TXFIFO  = 6'h00;
  localparam logic [5:0] API_RXFIFO  = 6'h04;
  localparam logic [5:0] API_STATE   = 6'h08;
  localparam logic [5:0] API_TIMEOUT = 6'h0C;
  localparam logic [5:0] API_SCK     = 6'h10;
  localparam logic [5:0] API_LW      = 6'h18;
  localparam logic [5:0] API_LWCTL   = 6'h1C;

  localparam logic [31:0] MAGIC_DEAD  = 32'hDEADDEAD;
  localparam logic [31:0] MAGIC_EMPTY = 32'h12345678;
  localparam logic [31:0] MAGIC_BEAF  = 32'hBEAFBEAF;

  localparam int ST_TXFULL  = 0;
  localparam int ST_FLUSH   = 1;
  localparam int ST_TXCNT   = 2;
  localparam int ST_STATE   = 13;
  localparam int ST_RXEMPTY = 16;
  localparam int ST_RXCNT   = 20;

  function automatic logic [31:0] state_word(input logic [9:0]  rxcnt,
                                             input logic        rxempty,
                                             input logic [2:0]  miner_state,
                                             input logic [10:0] txcnt,
                                             input logic        flush,
                                             input logic        txfull);
    logic [31:0] w;
    w = '0;
    w[ST_RXCNT +: 10]  = rxcnt;
    w[ST_RXEMPTY]      = rxempty;
    w[ST_STATE +: 3]   = miner_state;
    w[ST_TXCNT +: 11]  = txcnt;
    w[ST_FLUSH]        = flush;
    w[ST_TXFULL]       = txfull;
    return w;
  endfunction

endpackage

// File: rtl/api_lw_counter.sv
// Saturating per-miner local-work counter with snapshot-and-clear.
// A clear or snapshot coinciding with an increment leaves the counter at 1.
module api_lw_counter #(
  parameter int CNT_W = 24
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  input  logic             snap,
  output logic [CNT_W-1:0] value,
  output logic             sat
);

  always_ff @(posedge clk) begin
    if (rst) begin
      value <= '0;
      sat   <= 1'b0;
    end else if (clr || snap) begin
      value <= inc ? CNT_W'(1) : '0;
      sat   <= 1'b0;
    end else if (inc) begin
      if (&value) sat <= 1'b1;
      else        value <= value + CNT_W'(1);
    end
  end

endmodule

// File: rtl/api_slave_mc.sv
// Wishbone register slave bridging the CPU bus to the miner TX/RX FIFOs,
// control registers and a bank of per-miner saturating nonce counters.
module api_slave_mc
  import api_pkg::*;
#(
  parameter int          MINER_NUM   = 10,
  parameter int          CNT_W       = 24,
  parameter logic [3:0]  FLUSH_LEN   = 4'd4,
  parameter logic [4:0]  WORK_LO     = 5'd2,
  parameter logic [4:0]  WORK_HI     = 5'd9,
  parameter logic [27:0] TIMEOUT_RST = 28'h0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        API_STB_I,
  input  logic        API_WE_I,
  input  logic [5:0]  API_ADR_I,
  input  logic [31:0] API_DAT_I,
  output logic        API_ACK_O,
  output logic        API_ERR_O,
  output logic        API_RTY_O,
  output logic [31:0] API_DAT_O,
  output logic        txfifo_push,
  output logic [31:0] txfifo_din,
  input  logic [10:0] txcnt,
  input  logic        txfull,
  input  logic [9:0]  rxcnt,
  input  logic        rxempty,
  output logic        rxfifo_pop,
  input  logic [31:0] rxfifo_dout,
  output logic        reg_flush,
  input  logic [2:0]  reg_state,
  output logic [27:0] reg_timeout,
  output logic [7:0]  reg_sck,
  output logic [5:0]  reg_ch_num,
  output logic [8:0]  reg_word_num,
  input  logic        rx_fifo_wr_en,
  input  logic [31:0] rx_fifo_din,
  input  logic [3:0]  miner_id,
  input  logic [4:0]  work_cnt
);

  logic             accept, wr_acc, rd_acc;
  logic             lw_wr, clr_all;
  logic [3:0]       lw_idx;
  logic             window_vld, lw_vld;
  logic [31:0]      last_din;
  logic [3:0]       flush_cnt;
  logic [CNT_W-1:0] lw_snap;
  logic             lw_sat;
  logic [CNT_W-1:0] snap_val;
  logic             snap_sat;
  logic [15:0]      sat_mask;
  logic [31:0]      rd_data;

  logic [CNT_W-1:0]     cnt_val [MINER_NUM];
  logic [MINER_NUM-1:0] cnt_sat;

  assign accept = API_STB_I & ~API_ACK_O;
  assign wr_acc = accept & API_WE_I;
  assign rd_acc = accept & ~API_WE_I;

  assign API_ERR_O = 1'b0;
  assign API_RTY_O = 1'b0;

  // Pop only in the accept cycle so the head word is captured on the same edge.
  assign rxfifo_pop = rd_acc && (API_ADR_I == API_RXFIFO) && !rxempty;
  assign reg_flush  = (flush_cnt != 4'd0);

  assign lw_idx  = API_DAT_I[3:0];
  assign lw_wr   = wr_acc && (API_ADR_I == API_LW);
  assign clr_all = wr_acc && (API_ADR_I == API_LWCTL) && API_DAT_I[0];

  assign window_vld = rx_fifo_wr_en && (work_cnt >= WORK_LO) && (work_cnt <= WORK_HI);
  assign lw_vld     = window_vld && (rx_fifo_din != MAGIC_BEAF) && (rx_fifo_din != last_din)
                      && (rx_fifo_din != 32'h0) && (rx_fifo_din != 32'hFFFF_FFFF);

  for (genvar g = 0; g < MINER_NUM; g++) begin : g_cnt
    api_lw_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (lw_vld && (miner_id == 4'(g))),
      .clr   (clr_all),
      .snap  (lw_wr && (lw_idx == 4'(g))),
      .value (cnt_val[g]),
      .sat   (cnt_sat[g])
    );
  end

  // Indices past MINER_NUM fall through to zero, giving an empty snapshot.
  always_comb begin
    snap_val = '0;
    snap_sat = 1'b0;
    for (int i = 0; i < MINER_NUM; i++) begin
      if (lw_idx == 4'(i)) begin
        snap_val = cnt_val[i];
        snap_sat = cnt_sat[i];
      end
    end
  end

  always_comb begin
    sat_mask = '0;
    for (int i = 0; i < MINER_NUM; i++) sat_mask[i] = cnt_sat[i];
  end

  always_comb begin
    rd_data = MAGIC_DEAD;
    case (API_ADR_I)
      API_RXFIFO:  rd_data = rxempty ? MAGIC_EMPTY : rxfifo_dout;
      API_STATE:   rd_data = state_word(rxcnt, rxempty, reg_state, txcnt, reg_flush, txfull);
      API_TIMEOUT: rd_data = {4'b0, reg_timeout};
      API_SCK:     rd_data = {reg_word_num, 1'b0, reg_ch_num, 8'b0, reg_sck};
      API_LW: begin
        rd_data = '0;
        rd_data[CNT_W-1:0] = lw_snap;
        rd_data[31] = lw_sat;
      end
      API_LWCTL:   rd_data = {16'b0, sat_mask};
      default:     rd_data = MAGIC_DEAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      API_ACK_O    <= 1'b0;
      API_DAT_O    <= '0;
      txfifo_push  <= 1'b0;
      txfifo_din   <= '0;
      flush_cnt    <= '0;
      reg_timeout  <= TIMEOUT_RST;
      reg_sck      <= '0;
      reg_ch_num   <= '0;
      reg_word_num <= '0;
      lw_snap      <= '0;
      lw_sat       <= 1'b0;
      last_din     <= '0;
    end else begin
      API_ACK_O   <= accept;
      txfifo_push <= wr_acc && (API_ADR_I == API_TXFIFO);
      if (wr_acc && (API_ADR_I == API_TXFIFO)) txfifo_din <= API_DAT_I;
      if (rd_acc) API_DAT_O <= rd_data;

      if (wr_acc && (API_ADR_I == API_STATE) && API_DAT_I[1]) flush_cnt <= FLUSH_LEN;
      else if (flush_cnt != 4'd0)                               flush_cnt <= flush_cnt - 4'd1;

      if (wr_acc && (API_ADR_I == API_TIMEOUT)) reg_timeout <= API_DAT_I[27:0];
      if (wr_acc && (API_ADR_I == API_SCK)) begin
        reg_sck      <= API_DAT_I[7:0];
        reg_ch_num   <= API_DAT_I[21:16];
        reg_word_num <= API_DAT_I[31:23];
      end

      if (lw_wr) begin
        lw_snap <= snap_val;
        lw_sat  <= snap_sat;
      end
      if (window_vld) last_din <= rx_fifo_din;
    end
  end

endmodule

// File: tb/tb_api_slave_mc.sv
// Randomized self-checking bench for api_slave_mc against a queue/array model
// of the register map and nonce-counting rules (8-bit counters, 10 miners).
module tb_api_slave_mc;
  import api_pkg::*;

  localparam int NM = 10;
  localparam int CW = 8;
  localparam int CMAX = (1 << CW) - 1;

  logic        clk, rst;
  logic        API_STB_I, API_WE_I;
  logic [5:0]  API_ADR_I;
  logic [31:0] API_DAT_I;
  logic        API_ACK_O, API_ERR_O, API_RTY_O;
  logic [31:0] API_DAT_O;
  logic        txfifo_push;
  logic [31:0] txfifo_din;
  logic [10:0] txcnt;
  logic        txfull;
  logic [9:0]  rxcnt;
  logic        rxempty;
  logic        rxfifo_pop;
  logic [31:0] rxfifo_dout;
  logic        reg_flush;
  logic [2:0]  reg_state;
  logic [27:0] reg_timeout;
  logic [7:0]  reg_sck;
  logic [5:0]  reg_ch_num;
  logic [8:0]  reg_word_num;
  logic        rx_fifo_wr_en;
  logic [31:0] rx_fifo_din;
  logic [3:0]  miner_id;
  logic [4:0]  work_cnt;

  api_slave_mc #(.MINER_NUM(NM), .CNT_W(CW), .FLUSH_LEN(4'd4), .WORK_LO(5'd2),
                 .WORK_HI(5'd9), .TIMEOUT_RST(28'h0)) dut (
    .clk(clk), .rst(rst), .API_STB_I(API_STB_I), .API_WE_I(API_WE_I),
    .API_ADR_I(API_ADR_I), .API_DAT_I(API_DAT_I), .API_ACK_O(API_ACK_O),
    .API_ERR_O(API_ERR_O), .API_RTY_O(API_RTY_O), .API_DAT_O(API_DAT_O),
    .txfifo_push(txfifo_push), .txfifo_din(txfifo_din), .txcnt(txcnt), .txfull(txfull),
    .rxcnt(rxcnt), .rxempty(rxempty), .rxfifo_pop(rxfifo_pop), .rxfifo_dout(rxfifo_dout),
    .reg_flush(reg_flush), .reg_state(reg_state), .reg_timeout(reg_timeout),
    .reg_sck(reg_sck), .reg_ch_num(reg_ch_num), .reg_word_num(reg_word_num),
    .rx_fifo_wr_en(rx_fifo_wr_en), .rx_fifo_din(rx_fifo_din), .miner_id(miner_id),
    .work_cnt(work_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int push_n = 0;
  int pop_n  = 0;
  logic [31:0] push_last = '0;

  always @(negedge clk) begin
    if (txfifo_push) begin
      push_n++;
      push_last = txfifo_din;
    end
    if (rxfifo_pop) pop_n++;
  end

  // reference model
  int          m_cnt [16];
  bit          m_sat [16];
  logic [31:0] m_last;
  logic [7:0]  m_snap;
  bit          m_lsat;
  logic [27:0] m_timeout;
  logic [7:0]  m_sck;
  logic [5:0]  m_ch;
  logic [8:0]  m_word;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      m_cnt[i] = 0;
      m_sat[i] = 0;
    end
    m_last = '0; m_snap = '0; m_lsat = 0;
    m_timeout = '0; m_sck = '0; m_ch = '0; m_word = '0;
  endtask

  task automatic model_nonce(input int id, input int wc, input logic [31:0] din);
    if (wc >= 2 && wc <= 9) begin
      if (din != MAGIC_BEAF && din != m_last && din != 32'h0 && din != 32'hFFFF_FFFF && id < NM) begin
        if (m_cnt[id] == CMAX) m_sat[id] = 1;
        else m_cnt[id]++;
      end
      m_last = din;
    end
  endtask

  task automatic model_snap(input int idx);
    if (idx < NM) begin
      m_snap = 8'(m_cnt[idx]);
      m_lsat = m_sat[idx];
      m_cnt[idx] = 0;
      m_sat[idx] = 0;
    end else begin
      m_snap = '0;
      m_lsat = 0;
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_cnt[i] = 0;
      m_sat[i] = 0;
    end
  endtask

  function automatic logic [31:0] exp_lw();
    return {m_lsat, 23'b0, m_snap};
  endfunction

  function automatic logic [31:0] exp_lwctl();
    logic [31:0] r;
    r = '0;
    for (int i = 0; i < NM; i++) r[i] = m_sat[i];
    return r;
  endfunction

  function automatic logic [31:0] exp_sck();
    return {m_word, 1'b0, m_ch, 8'b0, m_sck};
  endfunction

  task automatic bus(input logic we, input logic [5:0] adr, input logic [31:0] dat,
                     output logic [31:0] rdata);
    chk("ack_idle", {31'b0, API_ACK_O}, 32'h0);
    API_STB_I = 1'b1; API_WE_I = we; API_ADR_I = adr; API_DAT_I = dat;
    step();
    chk("ack", {31'b0, API_ACK_O}, 32'h1);
    rdata = API_DAT_O;
    API_STB_I = 1'b0; API_WE_I = 1'b0;
    step();
    chk("ack_one", {31'b0, API_ACK_O}, 32'h0);
  endtask

  task automatic wr_reg(input logic [5:0] adr, input logic [31:0] dat);
    logic [31:0] d;
    bus(1'b1, adr, dat, d);
    case (adr)
      API_TIMEOUT: m_timeout = dat[27:0];
      API_SCK: begin m_sck = dat[7:0]; m_ch = dat[21:16]; m_word = dat[31:23]; end
      API_LW:      model_snap(int'(dat[3:0]));
      API_LWCTL:   if (dat[0]) model_clear();
      default: ;
    endcase
  endtask

  task automatic rd_reg(input string tag, input logic [5:0] adr, input logic [31:0] exp);
    logic [31:0] d;
    bus(1'b0, adr, 32'h0, d);
    chk(tag, d, exp);
  endtask

  task automatic nonce(input int id, input int wc, input logic [31:0] din);
    rx_fifo_wr_en = 1'b1; miner_id = 4'(id); work_cnt = 5'(wc); rx_fifo_din = din;
    model_nonce(id, wc, din);
    step();
    rx_fifo_wr_en = 1'b0;
  endtask

  task automatic flush_run(input bit rewrite, input int exp_high);
    int n;
    API_STB_I = 1'b1; API_WE_I = 1'b1; API_ADR_I = API_STATE; API_DAT_I = 32'h2;
    step();
    API_STB_I = 1'b0; API_WE_I = 1'b0;
    n = 0;
    for (int k = 0; k < 12; k++) begin
      if (reg_flush) n++;
      if (rewrite && k == 2) begin
        API_STB_I = 1'b1; API_WE_I = 1'b1; API_ADR_I = API_STATE; API_DAT_I = 32'h2;
      end else begin
        API_STB_I = 1'b0; API_WE_I = 1'b0;
      end
      step();
    end
    chk(rewrite ? "flush_restart_len" : "flush_len", n, exp_high);
  endtask

  initial begin
    logic [31:0] d, exp_state;
    int pb;
    rst = 1'b1;
    API_STB_I = 0; API_WE_I = 0; API_ADR_I = '0; API_DAT_I = '0;
    txcnt = '0; txfull = 0; rxcnt = '0; rxempty = 1; rxfifo_dout = '0; reg_state = '0;
    rx_fifo_wr_en = 0; rx_fifo_din = '0; miner_id = '0; work_cnt = '0;
    model_reset();
    repeat (3) step();
    rst = 1'b0;
    step();

    chk("rst_timeout_out", {4'b0, reg_timeout}, 32'h0);
    chk("rst_flush", {31'b0, reg_flush}, 32'h0);
    chk("rst_txpush", {31'b0, txfifo_push}, 32'h0);
    rd_reg("rst_timeout", API_TIMEOUT, 32'h0);
    rd_reg("rst_sck", API_SCK, 32'h0);
    rd_reg("rst_lw", API_LW, 32'h0);
    rd_reg("rst_lwctl", API_LWCTL, 32'h0);

    wr_reg(API_TIMEOUT, 32'hFFFF_FFFF);
    rd_reg("timeout_rb", API_TIMEOUT, 32'h0FFF_FFFF);
    chk("timeout_out", {4'b0, reg_timeout}, {4'b0, m_timeout});
    wr_reg(API_SCK, 32'hFFFF_FFFF);
    rd_reg("sck_rb", API_SCK, 32'hFFBF_00FF);
    chk("sck_fields", {9'b0, reg_word_num, reg_ch_num, reg_sck}, {9'b0, m_word, m_ch, m_sck});

    wr_reg(API_TXFIFO, 32'hCAFE_F00D);
    chk("tx_push_cnt", push_n, 1);
    chk("tx_push_data", push_last, 32'hCAFE_F00D);
    rd_reg("tx_read", API_TXFIFO, MAGIC_DEAD);
    rd_reg("unmapped_rd", 6'h14, MAGIC_DEAD);
    wr_reg(6'h14, 32'h1234_5678);
    rd_reg("unmapped_wr", API_TIMEOUT, {4'b0, m_timeout});
    chk("tx_no_extra_push", push_n, 1);

    pb = pop_n;
    rxempty = 1'b1; rxfifo_dout = 32'h5555_5555;
    rd_reg("rx_empty", API_RXFIFO, MAGIC_EMPTY);
    chk("rx_no_pop", pop_n, pb);
    rxempty = 1'b0; rxfifo_dout = 32'hA5A5_A5A5;
    rd_reg("rx_data", API_RXFIFO, 32'hA5A5_A5A5);
    chk("rx_one_pop", pop_n, pb + 1);
    rxempty = 1'b1;

    for (int t = 0; t < 4; t++) begin
      txcnt = 11'($urandom); txfull = 1'($urandom); rxcnt = 10'($urandom);
      rxempty = 1'($urandom); reg_state = 3'($urandom);
      exp_state = {2'b0, rxcnt, 3'b0, rxempty, reg_state, txcnt, 1'b0, txfull};
      rd_reg("state_rd", API_STATE, exp_state);
    end
    rxempty = 1'b1;

    flush_run(1'b0, 4);
    flush_run(1'b1, 7);

    nonce(3, 5, 32'h1);
    nonce(3, 5, 32'h1);
    nonce(3, 5, MAGIC_BEAF);
    nonce(3, 5, 32'h2);
    nonce(3, 5, 32'h0);
    nonce(3, 1, 32'h3);
    wr_reg(API_LW, 32'h3);
    rd_reg("lw_miner3", API_LW, 32'h2);
    wr_reg(API_LW, 32'h3);
    rd_reg("lw_miner3_again", API_LW, 32'h0);

    nonce(3, 9, 32'h5);
    nonce(3, 2, 32'h6);
    API_STB_I = 1; API_WE_I = 1; API_ADR_I = API_LW; API_DAT_I = 32'h3;
    rx_fifo_wr_en = 1; miner_id = 4'd3; work_cnt = 5'd5; rx_fifo_din = 32'h7777_0001;
    model_snap(3);
    model_nonce(3, 5, 32'h7777_0001);
    step();
    API_STB_I = 0; API_WE_I = 0; rx_fifo_wr_en = 0;
    step();
    rd_reg("sim_snap_old", API_LW, 32'h2);
    wr_reg(API_LW, 32'h3);
    rd_reg("sim_snap_new", API_LW, 32'h1);

    nonce(4, 4, 32'h7);
    nonce(4, 4, 32'h8);
    API_STB_I = 1; API_WE_I = 1; API_ADR_I = API_LWCTL; API_DAT_I = 32'h1;
    rx_fifo_wr_en = 1; miner_id = 4'd4; work_cnt = 5'd4; rx_fifo_din = 32'h9;
    model_clear();
    model_nonce(4, 4, 32'h9);
    step();
    API_STB_I = 0; API_WE_I = 0; rx_fifo_wr_en = 0;
    step();
    wr_reg(API_LW, 32'h4);
    rd_reg("clr_with_inc", API_LW, 32'h1);

    nonce(12, 5, 32'hABCD);
    wr_reg(API_LW, 32'd12);
    rd_reg("lw_idx_oob", API_LW, 32'h0);

    wr_reg(API_LWCTL, 32'h1);
    for (int i = 0; i < 256; i++) nonce(0, 6, 32'h1000_0000 + i);
    rd_reg("sat_mask_set", API_LWCTL, 32'h1);
    wr_reg(API_LW, 32'h0);
    rd_reg("sat_snap", API_LW, 32'h8000_00FF);
    rd_reg("sat_mask_clr", API_LWCTL, exp_lwctl());

    for (int it = 0; it < 400; it++) begin
      int act;
      act = $urandom_range(0, 9);
      if (act <= 5) begin
        int sel;
        logic [31:0] din;
        sel = $urandom_range(0, 7);
        case (sel)
          0: din = 32'h0;
          1: din = 32'hFFFF_FFFF;
          2: din = MAGIC_BEAF;
          3: din = m_last;
          default: din = 32'($urandom_range(1, 40));
        endcase
        nonce($urandom_range(0, 15), $urandom_range(0, 12), din);
      end else if (act == 6) begin
        wr_reg(API_LW, 32'($urandom_range(0, 15)));
        rd_reg("lw_rnd", API_LW, exp_lw());
      end else if (act == 7) begin
        rd_reg("lwctl_rnd", API_LWCTL, exp_lwctl());
      end else if (act == 8) begin
        wr_reg(API_TIMEOUT, $urandom);
        rd_reg("timeout_rnd", API_TIMEOUT, {4'b0, m_timeout});
      end else begin
        if ($urandom_range(0, 3) == 0) wr_reg(API_LWCTL, 32'h1);
        else wr_reg(API_LWCTL, $urandom & 32'hFFFF_FFFE);
      end
    end
    for (int i = 0; i < NM; i++) begin
      wr_reg(API_LW, 32'(i));
      rd_reg("lw_final", API_LW, exp_lw());
    end

    nonce(5, 5, 32'h4242);
    API_STB_I = 1; API_WE_I = 1; API_ADR_I = API_TIMEOUT; API_DAT_I = 32'h0123_4567;
    rst = 1'b1;
    step();
    chk("rst_drop_ack", {31'b0, API_ACK_O}, 32'h0);
    rst = 1'b0; API_STB_I = 0; API_WE_I = 0;
    model_reset();
    step();
    chk("rst_drop_ack2", {31'b0, API_ACK_O}, 32'h0);
    rd_reg("rst2_timeout", API_TIMEOUT, 32'h0);
    wr_reg(API_LW, 32'h5);
    rd_reg("rst2_lw", API_LW, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/api_slave_mc.md
# api_slave_mc

Wishbone register slave for the miner controller, with a parametrised miner count. It bridges the CPU bus to the TX/RX work FIFOs, the status and timing registers, and a bank of per-miner local-work counters. It extends the fixed-10-miner slave with the following:
- per-miner saturating counters instead of a global overflow wipe;
- atomic snapshot-and-clear;
- a sticky saturation mask;
- a parametrised flush pulse length;
- no pop of an empty RX FIFO.

It sits between the LM32 Wishbone fabric and the miner TX/RX datapath.

## Interface
Parameters:
- MINER_NUM, 10: number of miners / counters (1..16)
- CNT_W, 24: counter width (8..31)
- FLUSH_LEN, 4: reg_flush pulse length in cycles (1..15)
- WORK_LO, 2 / WORK_HI, 9: inclusive work_cnt window in which nonces are counted
- TIMEOUT_RST, 28'h0: reset value of reg_timeout

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- API_STB_I, API_WE_I  in  1  Wishbone strobe and write enable (CYC/LOCK/CTI/BTE/SEL are accepted and ignored)
- API_ADR_I  in  6  byte address
- API_DAT_I  in  32  write data
- API_ACK_O  out  1  acknowledge
- API_ERR_O, API_RTY_O  out  1  constant 0
- API_DAT_O  out  32  read data
- txfifo_push  out  1  TX FIFO write strobe
- txfifo_din  out  32  TX FIFO write data
- txcnt  in  11 / txfull  in  1  TX FIFO status
- rxcnt  in  10 / rxempty  in  1  RX FIFO status
- rxfifo_pop  out  1  RX FIFO read strobe
- rxfifo_dout  in  32  RX FIFO read data
- reg_flush  out  1  FIFO flush pulse
- reg_state  in  3  miner FSM state
- reg_timeout  out  28  work timeout
- reg_sck  out  8  SPI clock divider
- reg_ch_num  out  6  channel count
- reg_word_num  out  9  words per work
- rx_fifo_wr_en  in  1  nonce-write strobe from the receiver
- rx_fifo_din  in  32  nonce-write data
- miner_id  in  4  source miner of the current write
- work_cnt  in  5  word index of the current write

## Operation
Access rules:
- An access is accepted in any cycle with API_STB_I & ~API_ACK_O.
- Register decode uses only accepted cycles.
- Unmapped reads return 32'hDEADDEAD. Unmapped writes are ignored.

Register map:
- 0x00 TXFIFO
  - W: push API_DAT_I to the TX FIFO.
  - R: 32'hDEADDEAD.
- 0x04 RXFIFO, read only
  - rxempty=0: returns rxfifo_dout and pulses rxfifo_pop.
  - rxempty=1: returns 32'h12345678 and does not pop.
- 0x08 STATE
  - R: {2'b0, rxcnt, 3'b0, rxempty, reg_state, txcnt, reg_flush, txfull}.
  - W: API_DAT_I[1]=1 starts a flush pulse.
- 0x0C TIMEOUT, RW, bits [27:0].
- 0x10 SCK, RW: [7:0] reg_sck, [21:16] reg_ch_num, [31:23] reg_word_num. Other read bits are 0.
- 0x18 LW
  - W: idx = API_DAT_I[3:0]; snapshot counter[idx] into lw_snap and clear it.
  - W with idx ≥ MINER_NUM: lw_snap = 0, no counter is affected.
  - R: {lw_sat, zero pad, lw_snap[CNT_W-1:0]}.
- 0x1C LWCTL
  - W: bit0=1 clears all counters and the saturation mask.
  - R: {16-bit zero, sat_mask[15:0]}; bits ≥ MINER_NUM read 0.

Nonce counting:
- A write is window-valid when rx_fifo_wr_en and WORK_LO ≤ work_cnt ≤ WORK_HI.
- lw_vld requires all of:
  - the write is window-valid;
  - din ≠ 32'hBEAFBEAF;
  - din ≠ last_din;
  - din ≠ 0;
  - din ≠ 32'hFFFFFFFF.
- last_din updates on every window-valid write.
- On lw_vld, counter[miner_id] increments if miner_id < MINER_NUM. Other miner_id values are ignored.

Saturation:
- A counter stops at all-ones.
- An lw_vld arriving while the counter is at all-ones sets sat_mask[i].
- Snapshot-and-clear of index i copies sat_mask[i] into lw_sat and clears sat_mask[i].

## Timing
Bus:
- API_ACK_O is high the cycle after acceptance, for exactly one cycle.
- Back-to-back strobes are acknowledged every second cycle.
- API_DAT_O is registered and valid with ACK.
- txfifo_push and txfifo_din are registered, aligned with ACK.
- rxfifo_pop is combinational in the accept cycle. Its data is captured into API_DAT_O on that edge.

Flush:
- reg_flush rises the cycle after the write is accepted and stays high FLUSH_LEN cycles.
- A new flush write during a pulse restarts the count.

Simultaneous events:
- Snapshot and an lw_vld on the same index in the same cycle: the snapshot takes the old value and the counter becomes 1.
- Clear-all and lw_vld in the same cycle: the counter becomes 1.

Reset (synchronous):
- API_ACK_O, API_DAT_O, txfifo_push, txfifo_din, reg_flush, reg_sck, reg_ch_num, reg_word_num: 0.
- reg_timeout: TIMEOUT_RST.
- All counters, sat_mask, lw_snap, lw_sat, last_din: 0.
- Reset mid-access drops the access: no ACK is issued.

## Structure
- Package api_pkg holds:
  - address constants API_TXFIFO..API_LWCTL;
  - magic words DEADDEAD, 12345678 and BEAFBEAF;
  - the STATE field offsets.
- Sub-module api_lw_counter (CNT_W):
  - inputs: inc, clr, snap;
  - outputs: value and a saturation flag;
  - instantiated MINER_NUM times with a generate loop.

## Test plan
- Reset, then read 0x0C and 0x10 → 28'h0 and 32'h0.
- Write 0x0C = 32'hFFFFFFFF, then read back → 32'h0FFFFFFF. ACK appears exactly one cycle after STB.
- rxempty=1, read 0x04 → 32'h12345678 and rxfifo_pop never asserted. With rxempty=0 and dout=32'hA5A5A5A5 → 32'hA5A5A5A5 and a single-cycle pop.
- Write 0x08 bit1, FLUSH_LEN=4 → reg_flush high for 4 cycles. A rewrite on the 3rd high cycle → pulse extends to 4 cycles after the rewrite.
- Counting, miner 3:
  - Nonces 1, 1, BEAFBEAF, 2, 0 with work_cnt=5 → counter 2.
  - Nonce 3 with work_cnt=1 → ignored.
  - Snapshot idx 3 → LW reads 2; a second snapshot reads 0.
- CNT_W=8: 256 distinct nonces for miner 0 → counter 255, sat_mask bit0=1. Snapshot → bit31=1, value 255; sat_mask clears.
